dcache_line_refill: RTL and testbench
=====================================

# dcache_line_refill

Memory-side line refill/writeback engine for the data cache. It consumes the processor's cache-miss bus pulse (`dbus_en`/`dbus_address`) and first evicts the dirty victim line through the cache's writeback port. It then fetches the missed line from DRAM in beats and writes it into the cache in one full-line fill. It sits directly downstream of the processor's data-cache miss path and drives the cache's `dmem_*` fill/writeback ports.

## Interface
- `LOG2CACHELINESIZE`, 7: log2 of cache line width in bits (128).
- `LOG2DRAMWIDTHBITS`, 5: log2 of DRAM beat width in bits (32).
- Derived: `BEATS` = 2^(LOG2CACHELINESIZE-LOG2DRAMWIDTHBITS) (4); `BEATBYTES` = DRAM width/8 (4).

Ports:
- `clk` in 1: single clock for all logic.
- `resetn` in 1: asynchronous, active-low reset.
- `dbus_en` in 1: miss request pulse.
- `dbus_address` in 32: byte address of the request.
- `dbus_wren` in 1: request is a store. Informational only; the cache is write-allocate, so the fill is identical for loads and stores.
- `dbus_wait` out 1: engine busy.
- `dmem_filladdr` out 32: line-aligned fill/victim address.
- `dmem_filldata` out 2^LOG2CACHELINESIZE: assembled line.
- `dmem_fillwe` out 1: one-cycle line write strobe.
- `dmem_fillrddirty` out 1: one-cycle victim read request.
- `dmem_wbaddr` in 32: victim line base address.
- `dmem_wbdata` in 2^LOG2DRAMWIDTHBITS: current victim beat.
- `dmem_wbwe` in 1: victim is dirty.
- `dmem_wback` out 1: beat consumed; the cache advances to the next beat.
- `dram_address` out 32: DRAM byte address.
- `dram_read` out 1: DRAM read request.
- `dram_write` out 1: DRAM write request.
- `dram_writedata` out 2^LOG2DRAMWIDTHBITS: DRAM write beat.
- `dram_waitrequest` in 1: DRAM stall; a request is accepted in any cycle where it is asserted and `dram_waitrequest`=0.
- `dram_readdata` in 2^LOG2DRAMWIDTHBITS: DRAM read beat.
- `dram_readdatavalid` in 1: read beat returned, in order.

## Operation
- `line_addr` = `dbus_address` with the low LOG2CACHELINESIZE-3 bits cleared. It is captured in IDLE.
- States: IDLE, RDDIRTY, WBWAIT, WBCHECK, WRITEBACK, WBACK, RDISSUE, RDWAIT, FILL.
- **IDLE**
  - `dbus_en`=1 and `dbus_address[31]`=0: go to RDDIRTY.
  - `dbus_address[31]`=1 (uncached): ignored entirely.
  - `dbus_en` in any state other than IDLE: ignored.
- **RDDIRTY**: `dmem_fillrddirty`=1 and `dmem_filladdr`=`line_addr`. Go to WBWAIT, then WBCHECK.
- **WBCHECK**: sample `dmem_wbwe`.
  - 1: go to WRITEBACK with `wb_beat`=0.
  - 0: go to RDISSUE.
- **WRITEBACK**
  - Drive `dram_write`=1, `dram_address`=`dmem_wbaddr`+`wb_beat`*BEATBYTES, `dram_writedata`=`dmem_wbdata`.
  - On acceptance go to WBACK.
- **WBACK**: `dmem_wback`=1 for one cycle, `wb_beat`++.
  - Last beat done: go to RDISSUE.
  - Otherwise return to WRITEBACK. The next beat's `dmem_wbdata` is valid in that cycle.
- **RDISSUE**
  - Drive `dram_read`=1, `dram_address`=`line_addr`+`rd_beat`*BEATBYTES.
  - `rd_beat`++ on each acceptance.
  - After BEATS acceptances go to RDWAIT.
- **Return capture** (RDISSUE and RDWAIT): each `dram_readdatavalid` writes `dram_readdata` into line buffer slice [`ret_beat`], and `ret_beat`++. Beat 0 goes to the least-significant slice.
- **RDWAIT**: leave when `ret_beat`=BEATS (including a final return that arrives in the same cycle).
- **FILL**: `dmem_fillwe`=1 for one cycle, with `dmem_filladdr`=`line_addr` and `dmem_filldata`=line buffer. Return to IDLE.
- All beat counters are LOG2CACHELINESIZE-LOG2DRAMWIDTHBITS+1 bits wide and clear in IDLE.

## Timing
- `dbus_wait` = (state≠IDLE), driven from a register.
  - High from the cycle after the accepted `dbus_en`.
  - Low in the cycle after FILL.
- `dmem_fillwe`, `dmem_fillrddirty` and `dmem_wback` are single-cycle pulses and are never asserted together.
- `dmem_wbwe` is sampled exactly 2 cycles after `dmem_fillrddirty`.
- `dram_read`/`dram_write` and their address/data are held stable while `dram_waitrequest`=1.
- Minimum latency for a clean miss with zero-wait DRAM and read latency L: 3 + BEATS + L + 1 cycles from `dbus_en` to `dmem_fillwe`.
- Reset (asynchronous, any state):
  - State returns to IDLE and all counters and outputs go to 0.
  - Line buffer and `line_addr` go to 0.
  - An in-flight transaction is abandoned with no fill. Read returns arriving after reset are ignored, because `ret_beat` is only counted in RDISSUE/RDWAIT.

## Test plan
- **Clean load miss**: `dbus_address`=0x00001234, `dmem_wbwe`=0, DRAM returns 0xA0, 0xA1, 0xA2, 0xA3.
  - Reads go to 0x1230/0x1234/0x1238/0x123C.
  - One `dmem_fillwe` with `dmem_filladdr`=0x1230 and `dmem_filldata`=0x000000A3_000000A2_000000A1_000000A0.
  - `dbus_wait` falls the cycle after the fill.
- **Dirty store miss**: `dmem_wbwe`=1, `dmem_wbaddr`=0x8000.
  - Four DRAM writes to 0x8000..0x800C carry the cache's beats in order.
  - Four `dmem_wback` pulses, then the fill as in the clean case.
- **Stalls**: `dram_waitrequest` held high 3 cycles on each beat, read latency 5.
  - Address and data stay stable through each stall.
  - Exactly 4 reads and 4 writes are accepted; fill data is correct.
- **Uncached / busy**
  - `dbus_address`=0x80000010 with `dbus_en`=1: no DRAM activity, `dbus_wait` stays 0.
  - A second `dbus_en` while busy is ignored.
- **Reset mid-fill**: `resetn` asserted after 2 read returns.
  - All outputs go to 0 immediately and no `dmem_fillwe` is issued.
  - A new miss after reset completes normally.

Source files
------------

// File: rtl/dcache_line_refill_if.sv
// Signal bundle between the refill engine, the processor miss path, the cache
// fill/writeback ports and DRAM.
interface dcache_line_refill_if #(
  parameter int LOG2CACHELINESIZE = 7,
  parameter int LOG2DRAMWIDTHBITS = 5
);
  logic                                dbus_en;
  logic [31:0]                         dbus_address;
  logic                                dbus_wren;
  logic                                dbus_wait;
  logic [31:0]                         dmem_filladdr;
  logic [(1 << LOG2CACHELINESIZE)-1:0] dmem_filldata;
  logic                                dmem_fillwe;
  logic                                dmem_fillrddirty;
  logic [31:0]                         dmem_wbaddr;
  logic [(1 << LOG2DRAMWIDTHBITS)-1:0] dmem_wbdata;
  logic                                dmem_wbwe;
  logic                                dmem_wback;
  logic [31:0]                         dram_address;
  logic                                dram_read;
  logic                                dram_write;
  logic [(1 << LOG2DRAMWIDTHBITS)-1:0] dram_writedata;
  logic                                dram_waitrequest;
  logic [(1 << LOG2DRAMWIDTHBITS)-1:0] dram_readdata;
  logic                                dram_readdatavalid;

  modport slave (
    input  dbus_en, dbus_address, dbus_wren,
    input  dmem_wbaddr, dmem_wbdata, dmem_wbwe,
    input  dram_waitrequest, dram_readdata, dram_readdatavalid,
    output dbus_wait, dmem_filladdr, dmem_filldata, dmem_fillwe, dmem_fillrddirty, dmem_wback,
    output dram_address, dram_read, dram_write, dram_writedata
  );

  modport master (
    output dbus_en, dbus_address, dbus_wren,
    output dmem_wbaddr, dmem_wbdata, dmem_wbwe,
    output dram_waitrequest, dram_readdata, dram_readdatavalid,
    input  dbus_wait, dmem_filladdr, dmem_filldata, dmem_fillwe, dmem_fillrddirty, dmem_wback,
    input  dram_address, dram_read, dram_write, dram_writedata
  );
endinterface

// File: rtl/dcache_line_refill.sv
// Data-cache miss engine: evicts a dirty victim beat by beat to DRAM, then
// fetches the missed line from DRAM and writes it into the cache in one fill.
module dcache_line_refill #(
  parameter int LOG2CACHELINESIZE = 7,
  parameter int LOG2DRAMWIDTHBITS = 5
) (
  input logic            clk,
  input logic            resetn,
  dcache_line_refill_if.slave bus
);
  localparam int LINE_W     = 1 << LOG2CACHELINESIZE;
  localparam int DRAM_W     = 1 << LOG2DRAMWIDTHBITS;
  localparam int IDX_W      = LOG2CACHELINESIZE - LOG2DRAMWIDTHBITS;
  localparam int CNT_W      = IDX_W + 1;
  localparam int OFF_W      = LOG2CACHELINESIZE - 3;
  localparam int BEAT_SHIFT = LOG2DRAMWIDTHBITS - 3;
  localparam logic [CNT_W-1:0] BEATS     = CNT_W'(1 << IDX_W);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'((1 << IDX_W) - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RDDIRTY   = 4'd1,
    ST_WBWAIT    = 4'd2,
    ST_WBCHECK   = 4'd3,
    ST_WRITEBACK = 4'd4,
    ST_WBACK     = 4'd5,
    ST_RDISSUE   = 4'd6,
    ST_RDWAIT    = 4'd7,
    ST_FILL      = 4'd8
  } state_t;

  state_t             state_r, state_next_s;
  logic [CNT_W-1:0]   wb_beat_r, rd_beat_r, ret_beat_r;
  logic [31:0]        line_addr_r;
  logic [LINE_W-1:0]  line_buf_r;
  logic               dbus_wait_r;
  logic               miss_s, dram_accept_s, ret_fire_s;
  logic               fillwe_s, fillrddirty_s, wback_s, dram_read_s, dram_write_s;
  logic [31:0]        filladdr_s, dram_address_s;
  logic [DRAM_W-1:0]  dram_writedata_s;
  logic               unused_s;

  // Uncached addresses (bit 31 set) never start a refill.
  assign miss_s        = bus.dbus_en & ~bus.dbus_address[31];
  assign dram_accept_s = ~bus.dram_waitrequest;
  assign ret_fire_s    = bus.dram_readdatavalid &
                         ((state_r == ST_RDISSUE) | (state_r == ST_RDWAIT));
  assign unused_s      = ^{bus.dbus_wren, bus.dbus_address[OFF_W-1:0]};

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:      if (miss_s) state_next_s = ST_RDDIRTY; else state_next_s = ST_IDLE;
      ST_RDDIRTY:   state_next_s = ST_WBWAIT;
      ST_WBWAIT:    state_next_s = ST_WBCHECK;
      ST_WBCHECK:   if (bus.dmem_wbwe) state_next_s = ST_WRITEBACK; else state_next_s = ST_RDISSUE;
      ST_WRITEBACK: if (dram_accept_s) state_next_s = ST_WBACK; else state_next_s = ST_WRITEBACK;
      ST_WBACK:     if (wb_beat_r == LAST_BEAT) state_next_s = ST_RDISSUE; else state_next_s = ST_WRITEBACK;
      ST_RDISSUE:   if (dram_accept_s && (rd_beat_r == LAST_BEAT)) state_next_s = ST_RDWAIT;
                    else state_next_s = ST_RDISSUE;
      // A final return landing in the same cycle also completes the line.
      ST_RDWAIT:    if ((ret_beat_r == BEATS) || (ret_fire_s && (ret_beat_r == LAST_BEAT)))
                      state_next_s = ST_FILL;
                    else state_next_s = ST_RDWAIT;
      ST_FILL:      state_next_s = ST_IDLE;
      default:      state_next_s = ST_IDLE;
    endcase
  end

  // Beat counters, captured line address and assembled line buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_beat_r   <= '0;
      rd_beat_r   <= '0;
      ret_beat_r  <= '0;
      line_addr_r <= 32'h0000_0000;
      line_buf_r  <= '0;
    end else if (state_r == ST_IDLE) begin
      wb_beat_r  <= '0;
      rd_beat_r  <= '0;
      ret_beat_r <= '0;
      if (miss_s) begin
        line_addr_r <= {bus.dbus_address[31:OFF_W], {OFF_W{1'b0}}};
      end
    end else begin
      if (state_r == ST_WBACK) begin
        wb_beat_r <= wb_beat_r + CNT_ONE;
      end
      if ((state_r == ST_RDISSUE) && dram_accept_s) begin
        rd_beat_r <= rd_beat_r + CNT_ONE;
      end
      if (ret_fire_s) begin
        line_buf_r[ret_beat_r[IDX_W-1:0]*DRAM_W +: DRAM_W] <= bus.dram_readdata;
        ret_beat_r <= ret_beat_r + CNT_ONE;
      end
    end
  end

  // Busy flag registered from the next state so it tracks state != IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dbus_wait_r <= 1'b0;
    end else begin
      dbus_wait_r <= (state_next_s != ST_IDLE);
    end
  end

  // Per-state output decode; everything idles at zero.
  always_comb begin
    fillwe_s         = 1'b0;
    fillrddirty_s    = 1'b0;
    wback_s          = 1'b0;
    dram_read_s      = 1'b0;
    dram_write_s     = 1'b0;
    filladdr_s       = 32'h0000_0000;
    dram_address_s   = 32'h0000_0000;
    dram_writedata_s = '0;
    case (state_r)
      ST_RDDIRTY: begin
        fillrddirty_s = 1'b1;
        filladdr_s    = line_addr_r;
      end
      ST_WRITEBACK: begin
        dram_write_s     = 1'b1;
        dram_address_s   = bus.dmem_wbaddr + (32'(wb_beat_r) << BEAT_SHIFT);
        dram_writedata_s = bus.dmem_wbdata;
      end
      ST_WBACK: begin
        wback_s = 1'b1;
      end
      ST_RDISSUE: begin
        dram_read_s    = 1'b1;
        dram_address_s = line_addr_r + (32'(rd_beat_r) << BEAT_SHIFT);
      end
      ST_FILL: begin
        fillwe_s   = 1'b1;
        filladdr_s = line_addr_r;
      end
      default: begin
        fillwe_s = 1'b0;
      end
    endcase
  end

  assign bus.dbus_wait        = dbus_wait_r;
  assign bus.dmem_filladdr    = filladdr_s;
  assign bus.dmem_filldata    = line_buf_r;
  assign bus.dmem_fillwe      = fillwe_s;
  assign bus.dmem_fillrddirty = fillrddirty_s;
  assign bus.dmem_wback       = wback_s;
  assign bus.dram_address     = dram_address_s;
  assign bus.dram_read        = dram_read_s;
  assign bus.dram_write       = dram_write_s;
  assign bus.dram_writedata   = dram_writedata_s;
endmodule

// File: tb/tb_dcache_line_refill.sv
// Self-checking bench: cache/DRAM responder plus a line-level reference model.
module tb_dcache_line_refill;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  dcache_line_refill_if bus ();
  dcache_line_refill dut (.clk(clk), .resetn(resetn), .bus(bus));

  typedef struct { int due; logic [31:0] data; } ret_t;

  int tests_run, tests_failed;
  int cyc = 0;
  int cfg_stall = 0, cfg_lat = 1;
  logic cfg_dirty = 1'b0;
  logic [31:0] cfg_wbaddr = 32'h0;
  logic [31:0] wb_beats [4];
  int wb_idx;
  logic [31:0] dram_mem [logic [31:0]];
  ret_t retq [$];
  logic [31:0] rd_log [$];
  logic [31:0] wr_addr_log [$];
  logic [31:0] wr_data_log [$];
  logic [31:0] fill_addr_log [$];
  logic [127:0] fill_data_log [$];
  int fill_cyc, en_cyc, rd_cyc, rddirty_cnt, wback_cnt, overlap_cnt, stab_err, wait_hi_cnt, ret_cnt;
  int stall_cnt;
  logic pend, pend_rd, pend_wr;
  logic [31:0] pend_addr, pend_data;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (dram_mem.exists(a)) return dram_mem[a];
    else return a ^ 32'h5A5A_0000;
  endfunction

  task automatic clear_logs();
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    fill_addr_log.delete(); fill_data_log.delete(); retq.delete();
    fill_cyc = -1; en_cyc = -1; rd_cyc = -100;
    rddirty_cnt = 0; wback_cnt = 0; overlap_cnt = 0; stab_err = 0; wait_hi_cnt = 0; ret_cnt = 0;
    stall_cnt = 0; pend = 1'b0; wb_idx = 0;
  endtask

  // Cache and DRAM responder: observes each cycle at negedge and drives the next half.
  initial begin
    ret_t r;
    bus.dram_waitrequest = 1'b0; bus.dram_readdata = 32'h0; bus.dram_readdatavalid = 1'b0;
    bus.dmem_wbaddr = 32'h0; bus.dmem_wbdata = 32'h0; bus.dmem_wbwe = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.dmem_fillrddirty) begin rd_cyc = cyc; rddirty_cnt++; end
      if (bus.dmem_fillwe) begin
        fill_addr_log.push_back(bus.dmem_filladdr);
        fill_data_log.push_back(bus.dmem_filldata);
        fill_cyc = cyc;
      end
      if ((32'(bus.dmem_fillwe) + 32'(bus.dmem_fillrddirty) + 32'(bus.dmem_wback)) > 1) overlap_cnt++;
      if (bus.dbus_wait) wait_hi_cnt++;
      if (bus.dbus_en && en_cyc < 0) en_cyc = cyc;
      if (pend && (bus.dram_read !== pend_rd || bus.dram_write !== pend_wr ||
                   bus.dram_address !== pend_addr || (pend_wr && bus.dram_writedata !== pend_data)))
        stab_err++;
      if ((bus.dram_read || bus.dram_write) && stall_cnt < cfg_stall) begin
        bus.dram_waitrequest = 1'b1;
        stall_cnt++;
        pend = 1'b1; pend_rd = bus.dram_read; pend_wr = bus.dram_write;
        pend_addr = bus.dram_address; pend_data = bus.dram_writedata;
      end else begin
        bus.dram_waitrequest = 1'b0;
        pend = 1'b0; stall_cnt = 0;
        if (bus.dram_read) begin
          rd_log.push_back(bus.dram_address);
          r.due = cyc + cfg_lat; r.data = mem_rd(bus.dram_address);
          retq.push_back(r);
        end
        if (bus.dram_write) begin
          wr_addr_log.push_back(bus.dram_address);
          wr_data_log.push_back(bus.dram_writedata);
        end
      end
      if (retq.size() > 0 && retq[0].due <= cyc) begin
        bus.dram_readdatavalid = 1'b1; bus.dram_readdata = retq[0].data;
        void'(retq.pop_front()); ret_cnt++;
      end else begin
        bus.dram_readdatavalid = 1'b0; bus.dram_readdata = $urandom;
      end
      if (bus.dmem_wback) begin wback_cnt++; wb_idx++; end
      // Dirty flag is only truthful in the single cycle it must be sampled.
      bus.dmem_wbwe = (cyc == rd_cyc + 2) ? cfg_dirty : ~cfg_dirty;
      bus.dmem_wbaddr = cfg_wbaddr;
      bus.dmem_wbdata = wb_beats[wb_idx % 4];
    end
  end

  task automatic run_and_check_miss(input string name, input logic [31:0] addr, input logic dirty,
                                    input logic [31:0] wbaddr, input int stall, input int lat);
    logic [31:0] line;
    logic [127:0] exp_data;
    int exp_wr, exp_lat;
    bit done;
    line = {addr[31:4], 4'h0};
    for (int k = 0; k < 4; k++) exp_data[32*k +: 32] = mem_rd(line + 32'(4*k));
    exp_wr = dirty ? 4 : 0;
    exp_lat = 3 + 4 + lat + 1 + (dirty ? 8 : 0);
    clear_logs();
    cfg_dirty = dirty; cfg_wbaddr = wbaddr; cfg_stall = stall; cfg_lat = lat;
    @(posedge clk); #1;
    bus.dbus_en = 1'b1; bus.dbus_address = addr; bus.dbus_wren = 1'($urandom);
    @(negedge clk); #1;
    tests_run++;
    if (bus.dbus_wait !== 1'b0) begin tests_failed++; $display("FAIL %s wait_at_en: got %b expected 0", name, bus.dbus_wait); end
    @(posedge clk); #1;
    bus.dbus_en = 1'b0; bus.dbus_address = $urandom;
    @(negedge clk); #1;
    tests_run++;
    if (bus.dbus_wait !== 1'b1) begin tests_failed++; $display("FAIL %s wait_after_en: got %b expected 1", name, bus.dbus_wait); end
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      @(negedge clk); #1;
      if (fill_addr_log.size() > 0) done = 1'b1;
    end
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL %s fill_timeout: got no fill expected one", name); end
    if (done) begin
      tests_run++;
      if (bus.dbus_wait !== 1'b1) begin tests_failed++; $display("FAIL %s wait_at_fill: got %b expected 1", name, bus.dbus_wait); end
    end
    @(negedge clk); #1;
    tests_run++;
    if (bus.dbus_wait !== 1'b0) begin tests_failed++; $display("FAIL %s wait_after_fill: got %b expected 0", name, bus.dbus_wait); end
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (fill_addr_log.size() !== 1) begin tests_failed++; $display("FAIL %s fill_count: got %0d expected 1", name, fill_addr_log.size()); end
    if (fill_addr_log.size() > 0) begin
      tests_run++;
      if (fill_addr_log[0] !== line) begin tests_failed++; $display("FAIL %s fill_addr: got %h expected %h", name, fill_addr_log[0], line); end
      tests_run++;
      if (fill_data_log[0] !== exp_data) begin tests_failed++; $display("FAIL %s fill_data: got %h expected %h", name, fill_data_log[0], exp_data); end
    end
    tests_run++;
    if (rd_log.size() !== 4) begin tests_failed++; $display("FAIL %s read_count: got %0d expected 4", name, rd_log.size()); end
    for (int k = 0; k < rd_log.size() && k < 4; k++) begin
      tests_run++;
      if (rd_log[k] !== line + 32'(4*k)) begin tests_failed++; $display("FAIL %s read_addr%0d: got %h expected %h", name, k, rd_log[k], line + 32'(4*k)); end
    end
    tests_run++;
    if (wr_addr_log.size() !== exp_wr) begin tests_failed++; $display("FAIL %s write_count: got %0d expected %0d", name, wr_addr_log.size(), exp_wr); end
    for (int k = 0; k < wr_addr_log.size() && k < exp_wr; k++) begin
      tests_run++;
      if (wr_addr_log[k] !== wbaddr + 32'(4*k) || wr_data_log[k] !== wb_beats[k]) begin
        tests_failed++;
        $display("FAIL %s write%0d: got %h/%h expected %h/%h", name, k, wr_addr_log[k], wr_data_log[k], wbaddr + 32'(4*k), wb_beats[k]);
      end
    end
    tests_run++;
    if (wback_cnt !== exp_wr) begin tests_failed++; $display("FAIL %s wback_count: got %0d expected %0d", name, wback_cnt, exp_wr); end
    tests_run++;
    if (overlap_cnt !== 0 || stab_err !== 0) begin tests_failed++; $display("FAIL %s overlap/stability: got %0d/%0d expected 0/0", name, overlap_cnt, stab_err); end
    if (stall == 0) begin
      tests_run++;
      if (fill_cyc - en_cyc !== exp_lat) begin tests_failed++; $display("FAIL %s latency: got %0d expected %0d", name, fill_cyc - en_cyc, exp_lat); end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({bus.dbus_wait, bus.dram_read, bus.dram_write, bus.dmem_fillwe, bus.dmem_fillrddirty, bus.dmem_wback} !== 6'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b expected 000000", {bus.dbus_wait, bus.dram_read, bus.dram_write, bus.dmem_fillwe, bus.dmem_fillrddirty, bus.dmem_wback});
    end
    tests_run++;
    if (bus.dram_address !== 32'h0 || bus.dmem_filladdr !== 32'h0 || bus.dmem_filldata !== 128'h0) begin
      tests_failed++; $display("FAIL reset_data: got %h/%h/%h expected zeros", bus.dram_address, bus.dmem_filladdr, bus.dmem_filldata);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_clean_miss();
    for (int k = 0; k < 4; k++) begin dram_mem[32'h1230 + 32'(4*k)] = 32'hA0 + 32'(k); wb_beats[k] = $urandom; end
    run_and_check_miss("clean", 32'h0000_1234, 1'b0, 32'h0000_9000, 0, 3);
    tests_run++;
    if (fill_data_log.size() < 1 || fill_data_log[0] !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      tests_failed++; $display("FAIL clean_literal_data: got %0d fills expected A3A2A1A0 line", fill_data_log.size());
    end
    tests_run++;
    if (rd_log.size() < 4 || rd_log[0] !== 32'h1230 || rd_log[3] !== 32'h123C) begin
      tests_failed++; $display("FAIL clean_literal_reads: got %0d reads expected 1230..123C", rd_log.size());
    end
  endtask

  task automatic test_dirty_miss();
    for (int k = 0; k < 4; k++) begin dram_mem[32'h5670 + 32'(4*k)] = $urandom; wb_beats[k] = $urandom; end
    run_and_check_miss("dirty", 32'h0000_5678, 1'b1, 32'h0000_8000, 0, 2);
    tests_run++;
    if (wr_addr_log.size() < 4 || wr_addr_log[0] !== 32'h8000 || wr_addr_log[3] !== 32'h800C) begin
      tests_failed++; $display("FAIL dirty_literal_writes: got %0d writes expected 8000..800C", wr_addr_log.size());
    end
  endtask

  task automatic test_stalls();
    for (int k = 0; k < 4; k++) wb_beats[k] = $urandom;
    run_and_check_miss("stall", 32'h0000_1234, 1'b1, 32'h0000_8000, 3, 5);
  endtask

  task automatic test_uncached_busy();
    bit done;
    clear_logs(); cfg_dirty = 1'b0; cfg_stall = 0; cfg_lat = 2;
    @(posedge clk); #1; bus.dbus_en = 1'b1; bus.dbus_address = 32'h8000_0010;
    @(posedge clk); #1; bus.dbus_en = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    tests_run++;
    if (wait_hi_cnt !== 0 || rd_log.size() + wr_addr_log.size() + fill_addr_log.size() + rddirty_cnt !== 0) begin
      tests_failed++; $display("FAIL uncached: got wait=%0d activity=%0d expected 0/0", wait_hi_cnt, rd_log.size() + wr_addr_log.size() + fill_addr_log.size() + rddirty_cnt);
    end
    clear_logs();
    @(posedge clk); #1; bus.dbus_en = 1'b1; bus.dbus_address = 32'h0000_3330;
    @(posedge clk); #1; bus.dbus_en = 1'b0;
    repeat (3) @(posedge clk);
    #1; bus.dbus_en = 1'b1; bus.dbus_address = 32'h0000_4440;
    @(posedge clk); #1; bus.dbus_en = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin @(negedge clk); #1; if (fill_addr_log.size() > 0) done = 1'b1; end
    repeat (30) @(negedge clk);
    #1;
    tests_run++;
    if (fill_addr_log.size() !== 1 || rd_log.size() !== 4) begin
      tests_failed++; $display("FAIL busy_counts: got fills=%0d reads=%0d expected 1/4", fill_addr_log.size(), rd_log.size());
    end
    tests_run++;
    if (fill_addr_log.size() < 1 || fill_addr_log[0] !== 32'h0000_3330) begin
      tests_failed++; $display("FAIL busy_addr: got %0d fills expected one at 00003330", fill_addr_log.size());
    end
  endtask

  task automatic test_reset_mid_fill();
    bit done;
    for (int k = 0; k < 4; k++) dram_mem[32'h2A40 + 32'(4*k)] = $urandom;
    clear_logs(); cfg_dirty = 1'b0; cfg_stall = 0; cfg_lat = 3;
    @(posedge clk); #1; bus.dbus_en = 1'b1; bus.dbus_address = 32'h0000_2A44;
    @(posedge clk); #1; bus.dbus_en = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin @(negedge clk); #1; if (ret_cnt >= 2) done = 1'b1; end
    tests_run++;
    if (!done) begin tests_failed++; $display("FAIL midreset_returns: got %0d returns expected 2", ret_cnt); end
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    tests_run++;
    if ({bus.dbus_wait, bus.dram_read, bus.dram_write, bus.dmem_fillwe, bus.dmem_fillrddirty, bus.dmem_wback} !== 6'b0 ||
        bus.dram_address !== 32'h0 || bus.dmem_filldata !== 128'h0 || bus.dmem_filladdr !== 32'h0) begin
      tests_failed++; $display("FAIL midreset_outputs: got read=%b wait=%b data=%h expected zeros", bus.dram_read, bus.dbus_wait, bus.dmem_filldata);
    end
    repeat (2) @(negedge clk);
    #2; resetn = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    tests_run++;
    if (fill_addr_log.size() !== 0) begin tests_failed++; $display("FAIL midreset_nofill: got %0d fills expected 0", fill_addr_log.size()); end
    run_and_check_miss("after_reset", 32'h0000_2A48, 1'b0, 32'h0000_7000, 0, 2);
  endtask

  task automatic test_random_misses();
    logic [31:0] addr, line;
    for (int it = 0; it < 16; it++) begin
      addr = $urandom & 32'h7FFF_FFFF;
      line = {addr[31:4], 4'h0};
      for (int k = 0; k < 4; k++) begin dram_mem[line + 32'(4*k)] = $urandom; wb_beats[k] = $urandom; end
      run_and_check_miss("random", addr, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFF0,
                         int'($urandom_range(0, 2)), int'($urandom_range(1, 6)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tests_run = 0; tests_failed = 0;
    bus.dbus_en = 1'b0; bus.dbus_address = 32'h0; bus.dbus_wren = 1'b0;
    for (int k = 0; k < 4; k++) wb_beats[k] = 32'h0;
    clear_logs();
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_uncached_busy();
    test_reset_mid_fill();
    test_random_misses();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
